ps2_key_sender: RTL
===================

# ps2_key_sender

Device-side PS/2 keyboard emulator: turns key press/release events into Set-2 scancode byte streams and serialises them onto PS/2 clock/data lines. A press sends the make code. A release sends 0xF0 followed by the make code. It is the transmit end of the keyboard link that our scancode receiver and state machine consume, and it drives that receiver in loopback benches and on-board demos.

## Interface
- CLK_DIV, 2500: clk_50 cycles per PS/2 clock half-period (10 kHz at 50 MHz); must be ≥ 2.
- GAP, 5000: idle cycles (clock and data high) after each stop bit.
- TYPE_DELAY, 25_000_000: typematic first-repeat delay in cycles (used only with TYPEMATIC_EN).
- TYPE_RATE, 5_000_000: typematic repeat period in cycles (used only with TYPEMATIC_EN).
- clk_50  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  event request.
- key_code  in  8  Set-2 make code; 0xF0 and 0x00 are not legal codes.
- key_release  in  1  1 = release event, 0 = press event.
- key_ready  out  1  block can accept an event this cycle.
- ps2_clk  out  1  PS/2 clock line as driven by the device; idles high.
- ps2_data  out  1  PS/2 data line; idles high.
- busy  out  1  a frame or gap is in progress.
- byte_done  out  1  one-cycle pulse at the end of each stop-bit cell.

## Operation
- Reset values: ps2_clk=1, ps2_data=1, key_ready=1, busy=0, byte_done=0, pending=0, typematic disarmed. Asserting rst mid-frame abandons the frame immediately; no partial byte is resumed.
- Event acceptance:
  - An event is accepted when key_valid && key_ready; key_code and key_release are latched.
  - key_ready is high only in IDLE with no pending byte; it drops the cycle after acceptance.
  - key_valid held while key_ready=0 is ignored, not queued.
- Byte selection:
  - Press: shift register loads key_code.
  - Release: loads 0xF0 and sets pending with key_code saved. After the 0xF0 gap, the saved key_code is sent without returning to IDLE.
- FSM states:
  - IDLE -> FRAME on acceptance or a typematic fire.
  - FRAME: 11 bit cells, counter 0..10. Order is start=0, data bits LSB first, odd parity (XOR of data, inverted), stop=1.
  - FRAME -> GAP after cell 10.
  - GAP -> FRAME if pending (pending cleared); otherwise GAP -> IDLE.
- Bit cell: ps2_data changes only at cell start while ps2_clk=1. ps2_clk stays high for CLK_DIV cycles, then low for CLK_DIV cycles, so the host samples on the falling edge.
- busy=1 in FRAME and GAP.

## Timing
- Latency: ps2_data=0 (start bit) is driven on the cycle after acceptance. The first ps2_clk falling edge follows CLK_DIV cycles later.
- Frame duration is 22·CLK_DIV cycles. byte_done pulses in the last cycle of cell 10. ps2_clk is high again the next cycle.
- Press: 22·CLK_DIV+GAP cycles from acceptance until key_ready=1.
- Release: 2·(22·CLK_DIV+GAP) cycles from acceptance until key_ready=1.
- Counters are sized from parameters with $clog2. The divider counts 0..CLK_DIV-1 and wraps.

## Configuration
- TYPEMATIC_EN defined:
  - An accepted press arms auto-repeat with that code. When the make-code frame finishes (entering GAP), a counter starts.
  - After TYPE_DELAY cycles, the make code is resent. Further resends follow every TYPE_RATE cycles, each counted from the previous frame's GAP entry.
  - A fire that lands while busy waits for IDLE.
  - Any accepted event disarms the repeat. A press re-arms it with the new code.
  - If key_valid and a fire coincide in IDLE, the external event wins and the fire is dropped.
- TYPEMATIC_EN undefined: no repeat logic is synthesised and each press sends exactly one make code.

## Test plan
Bench parameters: CLK_DIV=4, GAP=8, TYPE_DELAY=400, TYPE_RATE=200.
- Press 0x1C -> ps2_data sampled at the 11 ps2_clk falling edges reads 0,0,0,1,1,1,0,0,0,0,1 (parity 0). byte_done pulses 88 cycles after acceptance. key_ready returns at cycle 96.
- Release 0x1C -> two frames:
  - First frame: 0,0,0,0,0,1,1,1,1,1,1 (0xF0, parity 1).
  - Second frame: the 0x1C frame, starting 96 cycles after the first.
  - Exactly two byte_done pulses; key_ready stays 0 throughout.
- Press 0x12 with key_valid held high for 50 cycles -> a single 0x12 frame (parity bit 1); no second frame.
- rst asserted at cycle 40 of a frame -> ps2_clk=ps2_data=1 and key_ready=1 asynchronously. A subsequent press of 0x1C produces a clean, complete frame.
- TYPEMATIC_EN, press 0x1C:
  - Repeat frames start 400 cycles after the first frame's GAP entry, then every 200 cycles.
  - Releasing 0x1C (accepted between repeats) stops the repeats after the release pair.
- TYPEMATIC_EN: key_valid asserted the same cycle a repeat fires -> the new event's frame is sent and no repeat frame is emitted that cycle.

Source files
------------

// File: rtl/ps2_key_sender.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_sender
// Brief    : Device-side PS/2 keyboard emulator. It turns press/release
//            events into Set-2 scancode frames on ps2_clk/ps2_data.
//            Define TYPEMATIC_EN to build in the make-code auto-repeat.
// Revision : 1.0
// ============================================================================
module ps2_key_sender #(
    parameter int CLK_DIV    = 2500,
    parameter int GAP        = 5000,
    parameter int TYPE_DELAY = 25_000_000,
    parameter int TYPE_RATE  = 5_000_000
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_release,
    output logic       key_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       byte_done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [3:0]       LAST_CELL = 4'd10;

    if (CLK_DIV < 2 || GAP < 1 || TYPE_DELAY < 1 || TYPE_RATE < 1) begin : g_param_check
        $error("ps2_key_sender: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               ps2_clk_q, ps2_clk_d;
    logic [3:0]         cell_q, cell_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [10:0]        frame_q, frame_d;
    logic               pending_q, pending_d;
    logic [7:0]         saved_q, saved_d;

    logic               w_accept;
    logic               w_rep_start;
    logic [7:0]         w_rep_code;

    // Whole frame held as an 11-bit shift register; bit 0 is the cell on the wire.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    assign key_ready = (state_q == S_IDLE) && !pending_q;
    assign busy      = (state_q != S_IDLE);
    assign byte_done = (state_q == S_FRAME) && !ps2_clk_q && (div_q == DIV_LAST)
                       && (cell_q == LAST_CELL);
    assign ps2_clk   = ps2_clk_q;
    assign ps2_data  = frame_q[0];
    assign w_accept  = key_valid && key_ready;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            ps2_clk_q <= 1'b1;
            cell_q    <= '0;
            gap_q     <= '0;
            frame_q   <= '1;
            pending_q <= 1'b0;
            saved_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            ps2_clk_q <= ps2_clk_d;
            cell_q    <= cell_d;
            gap_q     <= gap_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            saved_q   <= saved_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        ps2_clk_d = ps2_clk_q;
        cell_d    = cell_q;
        gap_d     = gap_q;
        frame_d   = frame_q;
        pending_d = pending_q;
        saved_d   = saved_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d   = S_FRAME;
                    div_d     = '0;
                    ps2_clk_d = 1'b1;
                    cell_d    = '0;
                    if (key_release) begin
                        frame_d   = frame_of(8'hF0);
                        pending_d = 1'b1;
                        saved_d   = key_code;
                    end else begin
                        frame_d   = frame_of(key_code);
                    end
                end else if (w_rep_start) begin
                    state_d   = S_FRAME;
                    div_d     = '0;
                    ps2_clk_d = 1'b1;
                    cell_d    = '0;
                    frame_d   = frame_of(w_rep_code);
                end
            end
            S_FRAME: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (ps2_clk_q) begin
                        ps2_clk_d = 1'b0;
                    end else begin
                        // Cell ends: raise the clock and present the next bit together.
                        ps2_clk_d = 1'b1;
                        frame_d   = {1'b1, frame_q[10:1]};
                        if (cell_q == LAST_CELL) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            cell_d  = cell_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (pending_q) begin
                        state_d   = S_FRAME;
                        pending_d = 1'b0;
                        div_d     = '0;
                        ps2_clk_d = 1'b1;
                        cell_d    = '0;
                        frame_d   = frame_of(saved_q);
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef TYPEMATIC_EN
    localparam int REP_MAX = (TYPE_DELAY > TYPE_RATE) ? TYPE_DELAY : TYPE_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(TYPE_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(TYPE_RATE - 1);

    logic             armed_q, armed_d;
    logic             counting_q, counting_d;
    logic             first_q, first_d;
    logic             fire_pend_q, fire_pend_d;
    logic [7:0]       rep_code_q, rep_code_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             w_fire;

    assign w_fire      = counting_q && (rep_cnt_q == (first_q ? DELAY_LAST : RATE_LAST));
    assign w_rep_start = (w_fire || fire_pend_q) && (state_q == S_IDLE) && !w_accept;
    assign w_rep_code  = rep_code_q;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            armed_q     <= 1'b0;
            counting_q  <= 1'b0;
            first_q     <= 1'b1;
            fire_pend_q <= 1'b0;
            rep_code_q  <= '0;
            rep_cnt_q   <= '0;
        end else begin
            armed_q     <= armed_d;
            counting_q  <= counting_d;
            first_q     <= first_d;
            fire_pend_q <= fire_pend_d;
            rep_code_q  <= rep_code_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    // Later assignments take priority: an accepted event overrides everything.
    always_comb begin
        armed_d     = armed_q;
        counting_d  = counting_q;
        first_d     = first_q;
        fire_pend_d = fire_pend_q;
        rep_code_d  = rep_code_q;
        rep_cnt_d   = rep_cnt_q;
        if (counting_q) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
        if (w_fire) begin
            counting_d  = 1'b0;
            fire_pend_d = 1'b1;
        end
        if (byte_done && armed_q) begin
            counting_d = 1'b1;
            rep_cnt_d  = '0;
        end
        if (w_rep_start) begin
            fire_pend_d = 1'b0;
            first_d     = 1'b0;
        end
        if (w_accept) begin
            armed_d     = !key_release;
            counting_d  = 1'b0;
            fire_pend_d = 1'b0;
            first_d     = 1'b1;
            rep_code_d  = key_code;
        end
    end
`else
    assign w_rep_start = 1'b0;
    assign w_rep_code  = 8'h00;
`endif

endmodule
`default_nettype wire
